sdram_upload: RTL and testbench

SDRAM_UPLOAD -- requirements
Module: sdram_upload

---
 rtl/sdram_upload_if.sv | 25 ++
 rtl/sdram_upload.sv | 118 +++++++++++
 tb/tb_sdram_upload.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_upload_if.sv
// HPS ioctl upload port and SDRAM read port of the upload block.
// master = HPS/SDRAM side, slave = the sdram_upload block.
interface sdram_upload_if;
    logic        ioctl_upload;
    logic [26:0] ioctl_addr;
    logic        ioctl_rd;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        sdram_req;
    logic        sdram_rnw;
    logic [26:0] sdram_addr;
    logic [31:0] sdram_dout;
    logic        sdram_ready;
    logic        upload_busy;

    modport master (
        output ioctl_upload, ioctl_addr, ioctl_rd, sdram_dout, sdram_ready,
        input  ioctl_din, ioctl_wait, sdram_req, sdram_rnw, sdram_addr, upload_busy
    );

    modport slave (
        input  ioctl_upload, ioctl_addr, ioctl_rd, sdram_dout, sdram_ready,
        output ioctl_din, ioctl_wait, sdram_req, sdram_rnw, sdram_addr, upload_busy
    );
endinterface

// File: rtl/sdram_upload.sv
// Serves HPS halfword reads from SDRAM through a one-word buffer; misses
// fetch a 32-bit word and stall the HPS until it arrives.
module sdram_upload #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned SIZE      = 131072
) (
    input  logic           clk1x,
    input  logic           reset_n,
    sdram_upload_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [27:0] SIZE_L = 28'(SIZE);
    localparam logic [26:0] BASE_L = 27'(BASE_ADDR);

    state_t      state_q, state_d;
    logic        init_q, init_d;
    logic        upload_q, upload_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_q, buf_d;
    logic [24:0] tag_q, tag_d;
    logic [24:0] wtag_q, wtag_d;
    logic [15:0] din_q, din_d;
    logic        wait_q, wait_d;
    logic [26:0] addr_q, addr_d;
    logic        hsel_q, hsel_d;

    logic [24:0] w;
    logic        in_range;
    logic        upload_rise;
    logic        rd_ok;

    assign w           = bus.ioctl_addr[26:2];
    assign in_range    = {1'b0, bus.ioctl_addr} < SIZE_L;
    assign upload_rise = bus.ioctl_upload & ~upload_q;
    // init_q holds off the first edge after reset release
    assign rd_ok       = bus.ioctl_rd & bus.ioctl_upload & init_q;

    always_comb begin
        state_d  = state_q;
        init_d   = 1'b1;
        upload_d = bus.ioctl_upload;
        valid_d  = valid_q & ~upload_rise;
        buf_d    = buf_q;
        tag_d    = tag_q;
        wtag_d   = wtag_q;
        din_d    = din_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        hsel_d   = hsel_q;

        unique case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    if (!in_range) begin
                        din_d = 16'h0000;
                    end else if (valid_q && !upload_rise && tag_q == w) begin
                        din_d = bus.ioctl_addr[1] ? buf_q[31:16] : buf_q[15:0];
                    end else begin
                        addr_d  = {w, 2'b00} + BASE_L;
                        hsel_d  = bus.ioctl_addr[1];
                        wtag_d  = w;
                        wait_d  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (bus.sdram_ready) begin
                    buf_d   = bus.sdram_dout;
                    tag_d   = wtag_q;
                    // a session that opened mid-fetch must not inherit this word
                    valid_d = ~upload_rise;
                    din_d   = hsel_q ? bus.sdram_dout[31:16] : bus.sdram_dout[15:0];
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            upload_q <= 1'b0;
            valid_q  <= 1'b0;
            buf_q    <= '0;
            tag_q    <= '0;
            wtag_q   <= '0;
            din_q    <= '0;
            wait_q   <= 1'b0;
            addr_q   <= '0;
            hsel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            upload_q <= upload_d;
            valid_q  <= valid_d;
            buf_q    <= buf_d;
            tag_q    <= tag_d;
            wtag_q   <= wtag_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            hsel_q   <= hsel_d;
        end
    end

    assign bus.ioctl_din   = din_q;
    assign bus.ioctl_wait  = wait_q;
    assign bus.sdram_req   = (state_q == REQ);
    assign bus.sdram_rnw   = 1'b1;
    assign bus.sdram_addr  = addr_q;
    assign bus.upload_busy = (state_q != IDLE);
endmodule

// File: tb/tb_sdram_upload.sv
// Directed bench for sdram_upload with a fixed-latency SDRAM read model.
module tb_sdram_upload;
    logic clk1x;
    logic reset_n;
    sdram_upload_if bus();

    sdram_upload #(.BASE_ADDR(1048576), .SIZE(8)) dut (
        .clk1x  (clk1x),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    // SDRAM model: ready is sampled by the DUT 5 edges after it samples req
    logic        pend, rdy;
    int          lat;
    logic [26:0] maddr;
    int          req_cnt;
    logic [26:0] last_req_addr;

    function automatic logic [31:0] model_word(input logic [26:0] a);
        case (a)
            27'h100000: model_word = 32'hAABB_CCDD;
            27'h100004: model_word = 32'h1122_3344;
            default:    model_word = 32'h0BAD_F00D;
        endcase
    endfunction

    initial begin
        pend = 1'b0; rdy = 1'b0; lat = 0; maddr = '0;
        req_cnt = 0; last_req_addr = '0;
    end

    always @(posedge clk1x) begin
        if (bus.sdram_req) begin
            pend  <= 1'b1;
            lat   <= 4;
            maddr <= bus.sdram_addr;
            req_cnt <= req_cnt + 1;
            last_req_addr <= bus.sdram_addr;
        end else if (pend) begin
            if (lat == 0) begin
                pend <= 1'b0;
                rdy  <= 1'b0;
            end else begin
                lat <= lat - 1;
                if (lat == 1) rdy <= 1'b1;
            end
        end
    end

    assign bus.sdram_ready = rdy;
    assign bus.sdram_dout  = rdy ? model_word(maddr) : 32'hDEAD_BEEF;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.ioctl_wait && cyc < 50) begin
            cyc++;
            @(negedge clk1x);
        end
    endtask

    task automatic do_rd(input logic [26:0] a, output int cyc);
        @(negedge clk1x);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        @(negedge clk1x);
        bus.ioctl_rd   = 1'b0;
        wait_idle(cyc);
    endtask

    typedef struct {
        logic [26:0] addr;
        logic [15:0] din;
        int          reqs;
        logic [26:0] req_addr;
        int          wait_cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, base;

        vecs[0] = '{27'd0,  16'hCCDD, 1, 27'h100000, 6};
        vecs[1] = '{27'd2,  16'hAABB, 0, 27'h0,      0};
        vecs[2] = '{27'd6,  16'h1122, 1, 27'h100004, 6};
        vecs[3] = '{27'd4,  16'h3344, 0, 27'h0,      0};
        vecs[4] = '{27'd8,  16'h0000, 0, 27'h0,      0};
        vecs[5] = '{27'd2,  16'hAABB, 1, 27'h100000, 6};
        vecs[6] = '{27'd11, 16'h0000, 0, 27'h0,      0};

        reset_n = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_addr   = '0;
        bus.ioctl_rd     = 1'b0;
        #22;
        chk("reset_din",  32'(bus.ioctl_din), 32'h0);
        chk("reset_wait", 32'(bus.ioctl_wait), 32'h0);
        chk("reset_req",  32'(bus.sdram_req), 32'h0);
        chk("reset_addr", 32'(bus.sdram_addr), 32'h0);
        chk("reset_busy", 32'(bus.upload_busy), 32'h0);
        chk("rnw",        32'(bus.sdram_rnw), 32'h1);
        @(negedge clk1x);
        reset_n = 1'b1;
        @(negedge clk1x);
        @(negedge clk1x);

        // read with no session open is ignored
        base = req_cnt;
        do_rd(27'd0, cyc);
        chk("noupl_busy", 32'(bus.upload_busy), 32'h0);
        chk("noupl_wait", 32'(cyc), 32'h0);
        chk("noupl_reqs", 32'(req_cnt - base), 32'h0);

        @(negedge clk1x);
        bus.ioctl_upload = 1'b1;
        for (int i = 0; i < 7; i++) begin
            base = req_cnt;
            do_rd(vecs[i].addr, cyc);
            chk($sformatf("v%0d_wait", i), 32'(cyc), 32'(vecs[i].wait_cyc));
            chk($sformatf("v%0d_din", i), 32'(bus.ioctl_din), 32'(vecs[i].din));
            chk($sformatf("v%0d_reqs", i), 32'(req_cnt - base), 32'(vecs[i].reqs));
            if (vecs[i].reqs != 0)
                chk($sformatf("v%0d_raddr", i), 32'(last_req_addr), 32'(vecs[i].req_addr));
        end

        // second read during WAIT is ignored
        base = req_cnt;
        @(negedge clk1x); bus.ioctl_addr = 27'd4; bus.ioctl_rd = 1'b1;
        @(negedge clk1x); bus.ioctl_rd = 1'b0;
        @(negedge clk1x); bus.ioctl_addr = 27'd6; bus.ioctl_rd = 1'b1;
        @(negedge clk1x); bus.ioctl_rd = 1'b0;
        wait_idle(cyc);
        @(negedge clk1x);
        chk("ign_reqs",  32'(req_cnt - base), 32'h1);
        chk("ign_din",   32'(bus.ioctl_din), 32'h3344);
        chk("ign_raddr", 32'(last_req_addr), 32'h100004);

        // session ends two cycles into WAIT; fetch still completes
        base = req_cnt;
        @(negedge clk1x); bus.ioctl_addr = 27'd0; bus.ioctl_rd = 1'b1;
        @(negedge clk1x); bus.ioctl_rd = 1'b0;
        @(negedge clk1x);
        @(negedge clk1x);
        @(negedge clk1x); bus.ioctl_upload = 1'b0;
        wait_idle(cyc);
        chk("drop_waitlo", 32'(bus.ioctl_wait), 32'h0);
        chk("drop_busy",   32'(bus.upload_busy), 32'h0);
        chk("drop_reqs",   32'(req_cnt - base), 32'h1);
        chk("drop_din",    32'(bus.ioctl_din), 32'hCCDD);

        // new session must refetch despite buffered word 0
        @(negedge clk1x); bus.ioctl_upload = 1'b1;
        base = req_cnt;
        do_rd(27'd0, cyc);
        chk("sess_reqs", 32'(req_cnt - base), 32'h1);
        chk("sess_wait", 32'(cyc), 32'h6);
        chk("sess_din",  32'(bus.ioctl_din), 32'hCCDD);

        // reset during WAIT, late ready afterwards
        base = req_cnt;
        @(negedge clk1x); bus.ioctl_addr = 27'd6; bus.ioctl_rd = 1'b1;
        @(negedge clk1x); bus.ioctl_rd = 1'b0;
        @(negedge clk1x);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.upload_busy), 32'h0);
        chk("rst_wait", 32'(bus.ioctl_wait), 32'h0);
        chk("rst_din",  32'(bus.ioctl_din), 32'h0);
        chk("rst_addr", 32'(bus.sdram_addr), 32'h0);
        chk("rst_req",  32'(bus.sdram_req), 32'h0);
        @(negedge clk1x); reset_n = 1'b1;
        repeat (8) @(negedge clk1x);
        chk("late_reqs", 32'(req_cnt - base), 32'h1);
        chk("late_din",  32'(bus.ioctl_din), 32'h0);
        chk("late_busy", 32'(bus.upload_busy), 32'h0);
        base = req_cnt;
        do_rd(27'd0, cyc);
        chk("post_reqs", 32'(req_cnt - base), 32'h1);
        chk("post_din",  32'(bus.ioctl_din), 32'hCCDD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
